// File: rtl/rdata_responder_pkg.sv
// Shared interconnect definitions: command encodings, slave status codes and the
// response record carried through the read latency pipeline.
package rdata_responder_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    W_ACK  = 2'd1,
    W_DATA = 2'd2,
    NO_REQ = 2'd3
  } status_e;

  typedef struct packed {
    logic [31:0] data;
    logic        id;
  } rsp_t;

endpackage

// File: rtl/rdata_responder_rsp_delay_line.sv
// Fixed-latency valid/data/id pipeline. Payload registers load only behind a valid
// bit, so the final stage keeps presenting the last delivered response while idle.
module rsp_delay_line
  import rdata_responder_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  input  logic        id_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        id_o,
  output logic        load_o
);

  logic [LAT-1:0] vld_q;
  rsp_t           stage_q [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= valid_i;
      if (valid_i) begin
        stage_q[0].data <= data_i;
        stage_q[0].id   <= id_i;
      end
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end
  end

  // load_o flags that the output stage captures a response at the coming edge.
  generate
    if (LAT == 1) begin : g_load_direct
      assign load_o = valid_i;
    end else begin : g_load_staged
      assign load_o = vld_q[LAT-2];
    end
  endgenerate

  assign valid_o = vld_q[LAT-1];
  assign data_o  = stage_q[LAT-1].data;
  assign id_o    = stage_q[LAT-1].id;

endmodule

// File: rtl/rdata_responder.sv
// Memory-backed slave: writes land immediately, reads return after LAT cycles with
// the number of in-flight reads capped at MAX_OUT.
module rdata_responder
  import rdata_responder_pkg::*;
#(
  parameter int LAT     = 1,
  parameter int MAX_OUT = 2,
  parameter int DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        cmd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        m_no,
  input  logic        s_no,
  output logic        ack,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        r_m_no,
  output logic        r_s_no
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [31:0]      mem_q [DEPTH];
  logic [CNT_W-1:0] outCnt_q, outCnt_d;
  logic             rSNo_q;
  logic [IDX_W-1:0] idx;
  logic             rdAck, wrAck, rspValid, rspLoad;
  logic             unusedAddr;

  // Upper address bits are dropped so addresses alias onto the word array.
  assign idx        = addr[IDX_W+1:2];
  assign unusedAddr = ^{addr[31:IDX_W+2], addr[1:0]};

  assign ack   = !rst && req && (cmd == CMD_WRITE || outCnt_q < CNT_W'(MAX_OUT));
  assign rdAck = ack && (cmd == CMD_READ);
  assign wrAck = ack && (cmd == CMD_WRITE);

  always_comb begin
    outCnt_d = outCnt_q;
    case ({rdAck, rspValid})
      2'b10:   outCnt_d = outCnt_q + CNT_W'(1);
      2'b01:   outCnt_d = outCnt_q - CNT_W'(1);
      default: outCnt_d = outCnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wrAck) begin
      mem_q[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outCnt_q <= '0;
      rSNo_q   <= 1'b0;
    end else begin
      outCnt_q <= outCnt_d;
      if (rspLoad) begin
        rSNo_q <= s_no;
      end
    end
  end

  rsp_delay_line #(
    .LAT(LAT)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .valid_i(rdAck),
    .data_i (mem_q[idx]),
    .id_i   (m_no),
    .valid_o(rspValid),
    .data_o (rdata),
    .id_o   (r_m_no),
    .load_o (rspLoad)
  );

  assign rvalid = rspValid;
  assign r_s_no = rSNo_q;

endmodule

// File: tb/tb_rdata_responder.sv
// Randomized and directed stimulus against a word-array/queue reference model; a
// negedge monitor scores every response cycle and every idle hold cycle.
module tb_rdata_responder;
  import rdata_responder_pkg::*;

  localparam int   LAT     = 3;
  localparam int   MAX_OUT = 2;
  localparam int   DEPTH   = 16;
  localparam logic S_NO    = 1'b1;

  logic        clk = 1'b0;
  logic        rst, req, cmd, m_no, s_no;
  logic [31:0] addr, wdata;
  logic        ack, rvalid, r_m_no, r_s_no;
  logic [31:0] rdata;

  typedef struct {
    logic [31:0] data;
    logic        mNo;
    int          due;
  } exp_t;

  exp_t        sbq [$];
  exp_t        monE;
  logic [31:0] model [DEPTH];
  logic [31:0] lastData;
  logic        lastM, lastS;
  logic        armed;
  int          cycle  = 0;
  int          checks = 0;
  int          passes = 0;

  rdata_responder #(
    .LAT(LAT), .MAX_OUT(MAX_OUT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
    .m_no(m_no), .s_no(s_no), .ack(ack), .rvalid(rvalid), .rdata(rdata),
    .r_m_no(r_m_no), .r_s_no(r_s_no)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
  endtask

  // One request cycle; the model decides acceptance from its own outstanding count.
  task automatic applyStimulus(input logic r, input logic c, input logic [31:0] a,
                               input logic [31:0] d, input logic m, output logic dutAck);
    logic expAck;
    int   idx;
    @(posedge clk);
    #1 req = r; cmd = c; addr = a; wdata = d; m_no = m;
    #1 expAck = r && !rst && (c == CMD_WRITE || sbq.size() < MAX_OUT);
    checkOutput("ack", {31'b0, ack}, {31'b0, expAck});
    dutAck = ack;
    idx = int'((a >> 2) % DEPTH);
    if (expAck) begin
      if (c == CMD_WRITE) model[idx] = d;
      else sbq.push_back('{model[idx], m, cycle + LAT});
    end
  endtask

  task automatic idle(input int n);
    logic dummy;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, CMD_READ, 32'h0, 32'h0, 1'b0, dummy);
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1 rst = 1'b1; req = 1'b1; cmd = CMD_READ; addr = 32'h4;
    #1 checkOutput("ack_in_reset", {31'b0, ack}, 32'h0);
    checkOutput("rvalid_in_reset", {31'b0, rvalid}, 32'h0);
    checkOutput("rdata_in_reset", rdata, 32'h0);
    checkOutput("r_m_no_in_reset", {31'b0, r_m_no}, 32'h0);
    checkOutput("r_s_no_in_reset", {31'b0, r_s_no}, 32'h0);
    sbq.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    lastData = 32'h0; lastM = 1'b0; lastS = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0; req = 1'b0;
  endtask

  // Monitor: pop the oldest expected read on every rvalid, otherwise demand held outputs.
  always @(negedge clk) begin
    if (armed && !rst) begin
      if (rvalid === 1'b1) begin
        if (sbq.size() == 0) begin
          checkOutput("rvalid_unexpected", {31'b0, rvalid}, 32'h0);
        end else begin
          monE = sbq.pop_front();
          checkOutput("rsp_cycle", cycle, monE.due);
          checkOutput("rdata", rdata, monE.data);
          checkOutput("r_m_no", {31'b0, r_m_no}, {31'b0, monE.mNo});
          checkOutput("r_s_no", {31'b0, r_s_no}, {31'b0, S_NO});
          lastData = monE.data; lastM = monE.mNo; lastS = S_NO;
        end
      end else begin
        if (sbq.size() > 0 && sbq[0].due <= cycle) begin
          checkOutput("rvalid_missing", {31'b0, rvalid}, 32'h1);
          void'(sbq.pop_front());
        end
        checkOutput("rdata_hold", rdata, lastData);
        checkOutput("r_m_no_hold", {31'b0, r_m_no}, {31'b0, lastM});
        checkOutput("r_s_no_hold", {31'b0, r_s_no}, {31'b0, lastS});
      end
    end
  end

  initial begin
    logic       a1;
    logic [2:0] pat;
    int         nAck, tries, firstAckCycle, thirdAckCycle;
    rst = 1'b0; req = 1'b0; cmd = CMD_READ; addr = '0; wdata = '0; m_no = 1'b0;
    s_no = S_NO; armed = 1'b0;
    resetDut();
    armed = 1'b1;

    $display("[TB] write then read-after-write with master 1");
    applyStimulus(1'b1, CMD_WRITE, 32'h4, 32'hA5A5_0001, 1'b0, a1);
    applyStimulus(1'b1, CMD_READ,  32'h4, 32'h0,         1'b1, a1);
    idle(LAT + 1);

    $display("[TB] address aliasing");
    applyStimulus(1'b1, CMD_WRITE, 32'h40, 32'h1111_1111, 1'b0, a1);
    applyStimulus(1'b1, CMD_READ,  32'h0,  32'h0,         1'b0, a1);
    idle(LAT + 1);

    $display("[TB] held read request against the outstanding limit");
    pat = '0; nAck = 0; tries = 0; firstAckCycle = -1; thirdAckCycle = -1;
    while (nAck < 3 && tries < 20) begin
      applyStimulus(1'b1, CMD_READ, 32'h40 + 32'(tries * 4), 32'h0, tries[0], a1);
      if (tries < 3) pat[2 - tries] = a1;
      if (a1 === 1'b1) begin
        if (nAck == 0) firstAckCycle = cycle;
        nAck++;
        if (nAck == 3) thirdAckCycle = cycle;
      end
      tries++;
    end
    checkOutput("ack_pattern", {29'b0, pat}, 32'b110);
    checkOutput("third_ack_cycle", thirdAckCycle, firstAckCycle + LAT + 1);
    idle(LAT + 2);

    $display("[TB] write while outstanding reads are at the limit");
    applyStimulus(1'b1, CMD_READ,  32'h8,  32'h0,         1'b0, a1);
    applyStimulus(1'b1, CMD_READ,  32'hC,  32'h0,         1'b1, a1);
    applyStimulus(1'b1, CMD_WRITE, 32'h8,  32'hDEAD_BEEF, 1'b0, a1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, CMD_READ, 32'h8, 32'h0, 1'b1, a1);
    idle(LAT + 2);

    $display("[TB] read accepted in the same cycle as a response");
    applyStimulus(1'b1, CMD_READ, 32'h4, 32'h0, 1'b0, a1);
    idle(LAT - 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, CMD_READ, 32'h4, 32'h0, 1'b1, a1);
    idle(LAT + 2);

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b1, CMD_READ, 32'h4, 32'h0, 1'b1, a1);
    applyStimulus(1'b1, CMD_READ, 32'h8, 32'h0, 1'b0, a1);
    resetDut();
    idle(LAT + 2);
    applyStimulus(1'b1, CMD_READ, 32'h4, 32'h0, 1'b1, a1);
    applyStimulus(1'b1, CMD_READ, 32'h40, 32'h0, 1'b0, a1);
    idle(LAT + 2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                    $urandom, $urandom, 1'($urandom_range(0, 1)), a1);
    end
    idle(LAT + 2);
    checkOutput("scoreboard_drained", sbq.size(), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
